// File: rtl/vanity_result_uart_tx.sv
// vanity_result_uart_tx: queues 64-bit match iteration counts and sends each
// one to the host as an 8N1 UART frame (SYNC_BYTE, then count bytes MSB first).
// Optional: define VANITY_TX_CHECKSUM_EN to append an XOR checksum byte of the
// eight count bytes, giving a 10-byte frame.
module vanity_result_uart_tx #(
  parameter int         BAUD_DIV  = 868,
  parameter int         FIFO_AW   = 2,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_match,
  input  logic [63:0] rx_cnt,
  output logic        tx_serial,
  output logic        tx_busy,
  output logic [7:0]  tx_dropped
);

  localparam int               DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_OCC = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [15:0]      BIT_LAST = 16'(BAUD_DIV - 1);
`ifdef VANITY_TX_CHECKSUM_EN
  localparam logic [3:0]       LAST_BYTE = 4'd9;
`else
  localparam logic [3:0]       LAST_BYTE = 4'd8;
`endif

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    STOP
  } state_t;

  // Result FIFO storage and control
  logic [63:0]        fifo_mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_reg;
  logic [FIFO_AW-1:0] rd_ptr_reg;
  logic [FIFO_AW:0]   occ_reg;
  logic [7:0]         dropped_reg;
  logic [63:0]        head_word;

  // Serialiser state
  state_t      state_reg;
  logic [15:0] timer_reg;
  logic [2:0]  bit_idx_reg;
  logic [3:0]  byte_idx_reg;
  logic [7:0]  byte_reg;
  logic [63:0] shift_reg;
  logic [7:0]  next_byte;
  logic        tx_serial_reg;
  logic        tx_busy_reg;

  logic fifo_full;
  logic push;
  logic pop;
  logic bit_end;

  // Occupancy is the registered value, so a full FIFO refuses a strobe even
  // when the head is popped in the same cycle.
  assign fifo_full = (occ_reg == FULL_OCC);
  assign push      = rx_match && !fifo_full;
  assign pop       = (state_reg == LOAD);
  assign bit_end   = (timer_reg == BIT_LAST);
  assign head_word = fifo_mem[rd_ptr_reg];

`ifdef VANITY_TX_CHECKSUM_EN
  logic [7:0] head_bytes [8];
  logic [7:0] head_csum;
  logic [7:0] csum_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_head_bytes
      assign head_bytes[gi] = head_word[8*gi +: 8];
    end
  endgenerate

  // XOR of the eight count bytes of the head entry, captured during LOAD
  always_comb begin
    head_csum = 8'h00;
    for (int i = 0; i < 8; i++) begin
      head_csum = head_csum ^ head_bytes[i];
    end
  end

  // After the last count byte the checksum follows
  assign next_byte = (byte_idx_reg == 4'd8) ? csum_reg : shift_reg[63:56];
`else
  assign next_byte = shift_reg[63:56];
`endif

  // FIFO storage write; only on an accepted strobe so X on rx_cnt never lands
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= rx_cnt;
    end
  end

  // FIFO pointers, occupancy and saturating drop counter
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      occ_reg     <= '0;
      dropped_reg <= 8'h00;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   occ_reg <= occ_reg + 1'b1;
        2'b01:   occ_reg <= occ_reg - 1'b1;
        default: occ_reg <= occ_reg;
      endcase
      if (rx_match && fifo_full && (dropped_reg != 8'hFF)) begin
        dropped_reg <= dropped_reg + 8'd1;
      end
    end
  end

  // Frame serialiser FSM with registered line output
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      timer_reg     <= 16'd0;
      bit_idx_reg   <= 3'd0;
      byte_idx_reg  <= 4'd0;
      byte_reg      <= 8'h00;
      shift_reg     <= 64'd0;
      tx_serial_reg <= 1'b1;
`ifdef VANITY_TX_CHECKSUM_EN
      csum_reg      <= 8'h00;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          timer_reg <= 16'd0;
          if (occ_reg != '0) begin
            state_reg <= LOAD;
          end
        end
        LOAD: begin
          shift_reg     <= head_word;
          byte_reg      <= SYNC_BYTE;
          byte_idx_reg  <= 4'd0;
          timer_reg     <= 16'd0;
          tx_serial_reg <= 1'b0;
`ifdef VANITY_TX_CHECKSUM_EN
          csum_reg      <= head_csum;
`endif
          state_reg     <= START;
        end
        START: begin
          if (bit_end) begin
            timer_reg     <= 16'd0;
            bit_idx_reg   <= 3'd0;
            tx_serial_reg <= byte_reg[0];
            state_reg     <= DATA;
          end else begin
            timer_reg <= timer_reg + 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            timer_reg <= 16'd0;
            if (bit_idx_reg == 3'd7) begin
              tx_serial_reg <= 1'b1;
              state_reg     <= STOP;
            end else begin
              // byte_reg shifts right so bit 1 is always the next one out
              bit_idx_reg   <= bit_idx_reg + 3'd1;
              tx_serial_reg <= byte_reg[1];
              byte_reg      <= {1'b0, byte_reg[7:1]};
            end
          end else begin
            timer_reg <= timer_reg + 16'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            timer_reg <= 16'd0;
            if (byte_idx_reg != LAST_BYTE) begin
              byte_idx_reg  <= byte_idx_reg + 4'd1;
              byte_reg      <= next_byte;
              shift_reg     <= {shift_reg[55:0], 8'h00};
              tx_serial_reg <= 1'b0;
              state_reg     <= START;
            end else begin
              state_reg <= IDLE;
            end
          end else begin
            timer_reg <= timer_reg + 16'd1;
          end
        end
        default: begin
          state_reg     <= IDLE;
          tx_serial_reg <= 1'b1;
        end
      endcase
    end
  end

  // Busy flag, one cycle behind the FIFO/FSM state it summarises
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_busy_reg <= 1'b0;
    end else begin
      tx_busy_reg <= (occ_reg != '0) || (state_reg != IDLE);
    end
  end

  assign tx_serial  = tx_serial_reg;
  assign tx_busy    = tx_busy_reg;
  assign tx_dropped = dropped_reg;

endmodule

// File: tb/tb_vanity_result_uart_tx.sv
// tb_vanity_result_uart_tx: directed bench for vanity_result_uart_tx with a
// small 8N1 line decoder; BAUD_DIV=4, FIFO depth 4.
module tb_vanity_result_uart_tx;

  localparam int BAUD = 4;
`ifdef VANITY_TX_CHECKSUM_EN
  localparam int NBYTES = 10;
`else
  localparam int NBYTES = 9;
`endif
  localparam int FRAME_CYC = NBYTES * 10 * BAUD;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_match;
  logic [63:0] rx_cnt;
  logic        tx_serial;
  logic        tx_busy;
  logic [7:0]  tx_dropped;

  int cyc = 0;
  int vec_cnt = 0;
  int miss_cnt = 0;

  vanity_result_uart_tx #(
    .BAUD_DIV  (BAUD),
    .FIFO_AW   (2),
    .SYNC_BYTE (8'hA5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_match   (rx_match),
    .rx_cnt     (rx_cnt),
    .tx_serial  (tx_serial),
    .tx_busy    (tx_busy),
    .tx_dropped (tx_dropped)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [63:0] cnt, input int idx);
    logic [7:0] x;
    x = 8'h00;
    if (idx == 0) return 8'hA5;
    if (idx <= 8) return cnt[8*(8-idx) +: 8];
    for (int k = 0; k < 8; k++) x = x ^ cnt[8*k +: 8];
    return x;
  endfunction

  // n back-to-back strobes with counts first, first+1, ...; starts and ends on a negedge
  task automatic strobe_seq(input logic [63:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      rx_match = 1'b1;
      rx_cnt   = first + 64'(i);
      @(negedge clk);
    end
    rx_match = 1'b0;
    rx_cnt   = 64'hDEAD_BEEF_DEAD_BEEF;
  endtask

  task automatic wait_start(input int limit, output int start_cyc);
    int n;
    n = 0;
    while (tx_serial !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    start_cyc = cyc;
    if (tx_serial !== 1'b0) check("start_timeout", 64'(tx_serial), 64'd0);
  endtask

  // Called on the first start-bit sample; returns on the first sample after the frame
  task automatic recv_frame(input logic [63:0] cnt, output int end_cyc);
    int         ferr;
    int         st;
    logic [9:0] bits;
    logic       s0;
    ferr = 0;
    st   = cyc;
    for (int i = 0; i < NBYTES; i++) begin
      for (int k = 0; k < 10; k++) begin
        s0 = tx_serial;
        for (int s = 0; s < BAUD; s++) begin
          if (tx_serial !== s0) ferr++;
          @(negedge clk);
        end
        bits[k] = s0;
      end
      if (bits[0] !== 1'b0 || bits[9] !== 1'b1) ferr++;
      check($sformatf("byte%0d", i), 64'(bits[8:1]), 64'(exp_byte(cnt, i)));
    end
    check("framing", 64'(ferr), 64'd0);
    end_cyc = cyc;
    check("frame_len", 64'(end_cyc - st), 64'(FRAME_CYC));
    $display("rx frame cnt=%016h start=%0d end=%0d", cnt, st, end_cyc);
  endtask

  task automatic count_lows(input int n, output int lows);
    lows = 0;
    for (int i = 0; i < n; i++) begin
      if (tx_serial !== 1'b1) lows++;
      @(negedge clk);
    end
  endtask

  task automatic single_frame(input logic [63:0] cnt);
    int s, st, e, lows;
    s = cyc;
    strobe_seq(cnt, 1);
    wait_start(20, st);
    check("latency", 64'(st - s), 64'd3);
    recv_frame(cnt, e);
    check("post_idle", 64'(tx_serial), 64'd1);
    check("busy_tail", 64'(tx_busy), 64'd1);
    @(negedge clk);
    check("busy_fall", 64'(tx_busy), 64'd0);
    count_lows(20, lows);
    check("quiet", 64'(lows), 64'd0);
  endtask

  initial begin
    int s, st, st2, e, lows;
    reset    = 1'b1;
    rx_match = 1'b0;
    rx_cnt   = 64'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_serial", 64'(tx_serial), 64'd1);
    check("rst_busy", 64'(tx_busy), 64'd0);
    check("rst_dropped", 64'(tx_dropped), 64'd0);

    // Single frame
    single_frame(64'h0123_4567_89AB_CDEF);

    // Overflow: 6 consecutive strobes, first pop makes room for the 5th
    s = cyc;
    fork
      strobe_seq(64'd1, 6);
      begin
        wait_start(20, st);
        check("ovf_latency", 64'(st - s), 64'd3);
        for (int f = 1; f <= 5; f++) begin
          recv_frame(64'(f), e);
          if (f == 1) check("ovf_dropped", 64'(tx_dropped), 64'd1);
          if (f < 5) begin
            wait_start(10, st2);
            check("ovf_gap", 64'(st2 - e), 64'd2);
          end
        end
      end
    join
    count_lows(20, lows);
    check("ovf_quiet", 64'(lows), 64'd0);
    check("ovf_busy", 64'(tx_busy), 64'd0);

    // Saturation: 5 accepted, 300 dropped
    strobe_seq(64'h100, 305);
    check("sat_dropped", 64'(tx_dropped), 64'd255);

    // Reset while a frame is running and the FIFO is full
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst1_serial", 64'(tx_serial), 64'd1);
    check("rst1_busy", 64'(tx_busy), 64'd0);
    check("rst1_dropped", 64'(tx_dropped), 64'd0);

    // Reset during DATA of byte 3 (0x45, bit 1 low) with 2 entries queued
    strobe_seq(64'h0123_4567_89AB_CDEF, 3);
    wait_start(20, st);
    repeat (129) @(negedge clk);
    check("pre_reset_low", 64'(tx_serial), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst2_serial", 64'(tx_serial), 64'd1);
    check("rst2_busy", 64'(tx_busy), 64'd0);
    check("rst2_dropped", 64'(tx_dropped), 64'd0);
    count_lows(500, lows);
    check("rst2_no_frame", 64'(lows), 64'd0);
    check("rst2_busy_idle", 64'(tx_busy), 64'd0);

    // New strobe after reset; also the checksum vector
    single_frame(64'h0000_0000_0000_00FF);

    // Push in the same cycle as LOAD pop with occupancy 1
    s = cyc;
    rx_match = 1'b1;
    rx_cnt   = 64'hAAAA_0000_0000_0001;
    @(negedge clk);
    rx_match = 1'b0;
    rx_cnt   = 64'hDEAD_BEEF_DEAD_BEEF;
    @(negedge clk);
    check("pp_occ_before", 64'(dut.occ_reg), 64'd1);
    rx_match = 1'b1;
    rx_cnt   = 64'h5555_0000_0000_0002;
    @(negedge clk);
    rx_match = 1'b0;
    rx_cnt   = 64'hDEAD_BEEF_DEAD_BEEF;
    check("pp_occ_after", 64'(dut.occ_reg), 64'd1);
    wait_start(20, st);
    check("pp_latency", 64'(st - s), 64'd3);
    recv_frame(64'hAAAA_0000_0000_0001, e);
    wait_start(10, st2);
    check("pp_gap", 64'(st2 - e), 64'd2);
    recv_frame(64'h5555_0000_0000_0002, e);
    count_lows(30, lows);
    check("pp_quiet", 64'(lows), 64'd0);
    check("pp_busy", 64'(tx_busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/vanity_result_uart_tx.md
Name: vanity_result_uart_tx

Overview:
Transmitter that reports vanity match results to the host over a UART serial line. It is the outbound counterpart of the host-to-FPGA parameter path that loads start point, range and reset. The top level strobes it with the 64-bit iteration count whenever the comparator reports a new match. The block queues each result, frames it and serialises it 8N1, so the host no longer has to poll the match counter.

Parameters:
BAUD_DIV, 868, mining_clk cycles per UART bit (100 MHz / 115200); legal range 2..65535
FIFO_AW, 2, log2 of result FIFO depth (default depth 4 entries of 64 bits)
SYNC_BYTE, 8'hA5, first byte of every frame

Ports:
clk  input  1  mining clock; all logic on posedge
reset  input  1  synchronous, active-high; clears FIFO, FSM, counters
rx_match  input  1  single-cycle strobe: new match, rx_cnt valid this cycle
rx_cnt  input  64  iteration count of the matching key, sampled when rx_match=1
tx_serial  output  1  UART line, idle high, 8N1, LSB first
tx_busy  output  1  high while FIFO non-empty or FSM not IDLE
tx_dropped  output  8  saturating count of results lost to FIFO full

Behaviour:
- Reset values: tx_serial=1, tx_busy=0, tx_dropped=0, FIFO empty, FSM=IDLE, bit timer=0. Reset mid-frame aborts the frame: tx_serial=1 the cycle after reset is sampled, and the queued entries are discarded.
- Push: on rx_match=1 with occupancy < 2^FIFO_AW (registered value, before any same-cycle pop), rx_cnt is written. This applies with no pop-then-push bypass: a strobe arriving while the FIFO is full is dropped even if a pop happens in the same cycle. On a dropped strobe, tx_dropped increments and saturates at 255.
- Frame: SYNC_BYTE, then rx_cnt bytes [63:56] down to [7:0] (9 bytes; 10 with the optional feature). Each byte is a start bit (0), data bits 0..7, and a stop bit (1). Each bit is held exactly BAUD_DIV cycles. There is no idle gap between bytes of a frame.
- FSM states:
  - IDLE: when FIFO is non-empty, go to LOAD.
  - LOAD: pop the head entry into a 64-bit shift register, set byte index=0, load SYNC_BYTE, go to START.
  - START: drive 0 for BAUD_DIV cycles, then go to DATA.
  - DATA: 8 bits, LSB first, BAUD_DIV cycles each, then go to STOP.
  - STOP: drive 1 for BAUD_DIV cycles. If bytes remain, load the next byte and go to START. Otherwise go to IDLE.
- Back-to-back frames: IDLE to LOAD costs 2 idle-high cycles between frames (STOP→IDLE, IDLE→LOAD). The start bit is asserted the cycle after LOAD.
- Latency: with FIFO empty and FSM in IDLE, a strobe in cycle N writes the FIFO at edge N+1, the FSM is in LOAD in cycle N+2, and tx_serial=0 from cycle N+3.
- Frame length: 90*BAUD_DIV cycles (100*BAUD_DIV with the optional feature).
- Bit timer: counts 0..BAUD_DIV-1 and reloads on each bit boundary; width is 16 bits.
- Pointers: binary, wrapping modulo 2^FIFO_AW. Occupancy counter has width FIFO_AW+1. Simultaneous push and pop with 0 < occupancy < full leaves occupancy unchanged.
- tx_busy is registered and reflects FIFO/FSM state one cycle late.
- rx_cnt is ignored when rx_match=0. X on rx_cnt in that case must not propagate.

Optional Feature:
Macro: VANITY_TX_CHECKSUM_EN.
- Defined: after byte [7:0], send one extra byte equal to the XOR of the 8 count bytes (SYNC_BYTE excluded), making a 10-byte frame. The checksum is accumulated during LOAD, not during shifting.
- Undefined: 9-byte frame, no checksum logic.

Test Plan:
- Single frame: BAUD_DIV=4; reset, then rx_match with rx_cnt=64'h0123_4567_89AB_CDEF. Expect tx_serial low 3 cycles later, and the decoded bytes A5,01,23,45,67,89,AB,CD,EF. Each bit lasts 4 cycles; frame ends at 360 cycles; tx_busy falls afterwards.
- Checksum (macro defined): rx_cnt=64'h0000_0000_0000_00FF. Expect bytes A5,00,00,00,00,00,00,00,FF,FF in 400 cycles.
- Overflow: FIFO_AW=2, 6 strobes on consecutive cycles with cnt=1..6. Expect the first pop at LOAD (cycle 3), which leaves 5 of 6 accepted; exactly one dropped (cnt=6); tx_dropped=1. Frames carry 1,2,3,4,5 in order with a 2-cycle idle gap between frames.
- Saturation: hold FIFO full and issue 300 dropped strobes. Expect tx_dropped=255.
- Reset mid-frame: assert reset during DATA of byte 3 with 2 entries queued. Expect tx_serial=1 the next cycle, tx_busy=0, tx_dropped=0, and no further frames until a new strobe.
- Simultaneous push/pop: strobe arriving exactly in the LOAD cycle with occupancy 1. Expect occupancy to stay at 1 and the new entry to be sent as the next frame.
